// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage register: occupancy states
// and control-bundle bit positions.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HALF  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int CTRL_WREG  = 0;
  localparam int CTRL_M2REG = 1;
  localparam int CTRL_WMEM  = 2;
  localparam int CTRL_BITS  = CTRL_WMEM + 1;

endpackage

// File: rtl/pipe_sat_counter.sv
// 32-bit event counter with synchronous clear that sticks at all-ones.
module pipe_sat_counter (
  input  logic        clock,
  input  logic        clr_i,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;

  always_ff @(posedge clock) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage register with a 2-entry skid buffer, flush and bubble gating.
// Define PIPE_STAGE_PERF_EN to build the stall/flush counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = CTRL_BITS,
  parameter int RN_W   = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RN_W-1:0]   in_rn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [RN_W-1:0]   out_rn,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
);

  logic [1:0]        state_q, state_d;
  logic              in_ready_q;
  logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
  logic [DATA_W-1:0] main_data_q, skid_data_q;
  logic [RN_W-1:0]   main_rn_q, skid_rn_q;

  logic in_xfer, out_xfer;
  logic load_main, load_skid, pop_skid;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_ready  = in_ready_q;
  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d   = ST_HALF;
            load_main = 1'b1;
          end
        end
        ST_HALF: begin
          if (in_xfer && out_xfer) begin
            load_main = 1'b1;
          end else if (in_xfer) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            state_d  = ST_HALF;
            pop_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // in_ready comes from the next state only, never from out_ready
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      main_rn_q   <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_rn_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      if (load_main) begin
        main_ctrl_q <= in_ctrl;
        main_data_q <= in_data;
        main_rn_q   <= in_rn;
      end else if (pop_skid) begin
        main_ctrl_q <= skid_ctrl_q;
        main_data_q <= skid_data_q;
        main_rn_q   <= skid_rn_q;
      end
      if (load_skid) begin
        skid_ctrl_q <= in_ctrl;
        skid_data_q <= in_data;
        skid_rn_q   <= in_rn;
      end
    end
  end

  assign out_ctrl = main_ctrl_q & {CTRL_W{out_valid}};
  assign out_rn   = out_valid ? main_rn_q : '0;
  assign out_data = main_data_q;

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter u_stall_cnt (
    .clock (clock),
    .clr_i (reset),
    .en_i  (out_valid & ~out_ready),
    .cnt_o (stall_cnt)
  );

  pipe_sat_counter u_flush_cnt (
    .clock (clock),
    .clr_i (reset),
    .en_i  (flush & (state_q != ST_EMPTY)),
    .cnt_o (flush_cnt)
  );
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a queue scoreboard and a
// negedge monitor that checks every output transfer and every bubble.
module tb_pipe_stage_reg;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ctrl;
  logic [31:0] in_data;
  logic [4:0]  in_rn;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_ctrl;
  logic [31:0] out_data;
  logic [4:0]  out_rn;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int nchk = 0;
  int nerr = 0;
  int nout = 0;
  int n0;
  logic [39:0] exp_q[$];

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(3), .RN_W(5)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .in_rn     (in_rn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .out_rn    (out_rn),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [31:0] d,
                     input logic [2:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
    in_rn    = d[4:0];
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Pop on output transfer; drop pending entries on reset/flush.
  always @(negedge clock) begin
    logic [39:0] e;
    if (!reset) begin
      if (out_valid && out_ready) begin
        nout++;
        if (exp_q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL unexpected_out: got data %h expected none",
                   out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_payload", {24'd0, out_ctrl, out_data, out_rn},
              {24'd0, e});
        end
      end
      if (out_valid === 1'b0)
        chk("bubble_ctrl_rn", {56'd0, out_ctrl, out_rn}, 64'd0);
    end
    if (reset || flush)
      exp_q.delete();
    else if (in_valid && in_ready)
      exp_q.push_back({in_ctrl, in_data, in_rn});
  end

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drv(1'b1, 32'h99, 3'b111);

    // reset with in_valid high
    repeat (2) begin
      step();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_ctrl", {61'd0, out_ctrl}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
      chk("rst_flush_cnt", {32'd0, flush_cnt}, 64'd0);
    end
    reset = 1'b0;
    drv(1'b0, 32'h0, 3'b000);

    // streaming at full rate
    out_ready = 1'b1;
    n0 = nout;
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 32'h10 + i, 3'b101);
      chk("stream_valid", {63'd0, out_valid}, {63'd0, (i != 0)});
      step();
    end
    drv(1'b0, 32'h0, 3'b000);
    chk("stream_last_valid", {63'd0, out_valid}, 64'd1);
    chk("stream_last_data", {32'd0, out_data}, 64'h17);
    step();
    chk("stream_count", 64'(nout - n0), 64'd8);
    chk("stream_drained", {63'd0, out_valid}, 64'd0);

    // downstream stall fills the skid entry
    out_ready = 1'b0;
    drv(1'b1, 32'h20, 3'b011);
    step();
    chk("skid_ready_half", {63'd0, in_ready}, 64'd1);
    drv(1'b1, 32'h21, 3'b011);
    step();
    chk("skid_ready_full", {63'd0, in_ready}, 64'd0);
    chk("skid_main_data", {32'd0, out_data}, 64'h20);
    drv(1'b1, 32'h22, 3'b011);
    repeat (2) begin
      step();
      chk("skid_hold_ready", {63'd0, in_ready}, 64'd0);
      chk("skid_hold_data", {32'd0, out_data}, 64'h20);
    end
    out_ready = 1'b1;
    step();
    chk("skid_pop_ready", {63'd0, in_ready}, 64'd1);
    chk("skid_pop_data", {32'd0, out_data}, 64'h21);
    step();
    drv(1'b0, 32'h0, 3'b000);
    chk("skid_last_data", {32'd0, out_data}, 64'h22);
    step();
    chk("skid_empty", {63'd0, out_valid}, 64'd0);

    // flush while FULL with a new input offered
    out_ready = 1'b0;
    drv(1'b1, 32'h30, 3'b111);
    step();
    drv(1'b1, 32'h31, 3'b111);
    step();
    drv(1'b1, 32'h32, 3'b111);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drv(1'b0, 32'h0, 3'b000);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_ctrl", {61'd0, out_ctrl}, 64'd0);
    chk("flush_ready", {63'd0, in_ready}, 64'd1);
`ifdef PIPE_STAGE_PERF_EN
    chk("flush_cnt_full", {32'd0, flush_cnt}, 64'd1);
`else
    chk("flush_cnt_full", {32'd0, flush_cnt}, 64'd0);
`endif

    // flush while HALF drops an acceptable input
    drv(1'b1, 32'h33, 3'b111);
    step();
    drv(1'b1, 32'h34, 3'b111);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drv(1'b0, 32'h0, 3'b000);
    chk("flush_half_valid", {63'd0, out_valid}, 64'd0);
    // flush while EMPTY must not count
    flush = 1'b1;
    step();
    flush = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
    chk("flush_cnt_empty", {32'd0, flush_cnt}, 64'd2);
`else
    chk("flush_cnt_empty", {32'd0, flush_cnt}, 64'd0);
`endif
    out_ready = 1'b1;
    repeat (3) step();
    chk("flush_no_resurface", {63'd0, out_valid}, 64'd0);

    // reset and flush together while HALF
    out_ready = 1'b0;
    drv(1'b1, 32'h40, 3'b110);
    step();
    drv(1'b0, 32'h0, 3'b000);
    step();
    chk("half_before_rst", {63'd0, out_valid}, 64'd1);
    reset = 1'b1;
    flush = 1'b1;
    step();
    reset = 1'b0;
    flush = 1'b0;
    chk("rf_valid", {63'd0, out_valid}, 64'd0);
    chk("rf_ctrl", {61'd0, out_ctrl}, 64'd0);
    chk("rf_rn", {59'd0, out_rn}, 64'd0);
    chk("rf_data", {32'd0, out_data}, 64'd0);
    chk("rf_ready", {63'd0, in_ready}, 64'd1);
    chk("rf_flush_cnt", {32'd0, flush_cnt}, 64'd0);
    chk("rf_stall_cnt", {32'd0, stall_cnt}, 64'd0);

    // stall counting and saturation
    drv(1'b1, 32'h50, 3'b001);
    step();
    drv(1'b0, 32'h0, 3'b000);
    chk("stall_start", {32'd0, stall_cnt}, 64'd0);
    repeat (5) step();
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_five", {32'd0, stall_cnt}, 64'd5);
    force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
    @(negedge clock);
    release dut.u_stall_cnt.cnt_q;
    #1;
    chk("stall_forced", {32'd0, stall_cnt}, 64'hFFFF_FFFE);
    repeat (3) step();
    chk("stall_saturate", {32'd0, stall_cnt}, 64'hFFFF_FFFF);
`else
    chk("stall_five", {32'd0, stall_cnt}, 64'd0);
    repeat (3) step();
    chk("stall_saturate", {32'd0, stall_cnt}, 64'd0);
`endif
    out_ready = 1'b1;
    repeat (2) step();
    chk("final_empty", {63'd0, out_valid}, 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
